ysyx_040066_dmem_resp: RTL and testbench

//  Memory-side responder for the core's data port (MemRd/MemWr/addr/wr_len/wr_mask/data_Wr ->

---
 rtl/ysyx_040066_dmem_resp_if.sv | 23 ++
 rtl/ysyx_040066_dmem_resp.sv | 168 ++++++++++++++++
 tb/tb_ysyx_040066_dmem_resp.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_040066_dmem_resp_if.sv
// Data-port bundle between the core (master) and the data-memory responder (slave).
interface ysyx_040066_dmem_resp_if;
    logic        MemRd;
    logic        MemWr;
    logic [63:0] addr;
    logic [2:0]  wr_len;
    logic [7:0]  wr_mask;
    logic [63:0] data_Wr;
    logic [63:0] data_Rd;
    logic        data_valid;
    logic        data_error;
    logic        busy;

    modport master (
        output MemRd, MemWr, addr, wr_len, wr_mask, data_Wr,
        input  data_Rd, data_valid, data_error, busy
    );

    modport slave (
        input  MemRd, MemWr, addr, wr_len, wr_mask, data_Wr,
        output data_Rd, data_valid, data_error, busy
    );
endinterface

// File: rtl/ysyx_040066_dmem_resp.sv
// Data-side memory responder: fixed-latency SRAM window with range/alignment/protocol fault flagging.
module ysyx_040066_dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_040066_dmem_resp_if.slave    bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = 4;
    localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
    localparam logic [63:0] END_ADDR = BASE_ADDR + SPAN;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Backing store; contents survive reset.
    logic [63:0] mem [DEPTH_WORDS];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       mask_q, mask_d;
    logic [63:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             data_valid_q, data_valid_d;
    logic             data_error_q, data_error_d;
    logic             busy_q, busy_d;
    logic [63:0]      data_rd_q, data_rd_d;

    logic             misalign_c;
    logic             req_err_c;
    logic [IDX_W-1:0] req_idx_c;
    logic             mem_we_c;

    // Fault classification and word index of the request currently on the bus.
    always_comb begin
        misalign_c = 1'b0;
        case (bus.wr_len)
            3'd0:    misalign_c = 1'b0;
            3'd1:    misalign_c = bus.addr[0];
            3'd2:    misalign_c = |bus.addr[1:0];
            3'd3:    misalign_c = |bus.addr[2:0];
            default: misalign_c = 1'b1;
        endcase
        req_err_c = (bus.MemRd && bus.MemWr)
                  || (bus.wr_len > 3'd3)
                  || misalign_c
                  || (bus.addr < BASE_ADDR)
                  || (bus.addr >= END_ADDR);
        // Base is window-aligned, so the in-window word index is just the address bits above the byte lane.
        req_idx_c = bus.addr[IDX_W+2:3];
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_wr_d      = op_wr_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        data_valid_d = 1'b0;
        data_error_d = 1'b0;
        busy_d       = 1'b0;
        data_rd_d    = '0;
        mem_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.MemRd || bus.MemWr) begin
                    op_wr_d = bus.MemWr;
                    idx_d   = req_idx_c;
                    mask_d  = bus.wr_mask;
                    wdata_d = bus.data_Wr;
                    err_d   = req_err_c;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        data_valid_d = 1'b1;
                        data_error_d = req_err_c;
                        if (!bus.MemWr && !req_err_c) begin
                            data_rd_d = mem[req_idx_c];
                        end
                    end else begin
                        state_d = S_WAIT;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = S_RESP;
                    data_valid_d = 1'b1;
                    data_error_d = err_q;
                    if (!op_wr_q && !err_q) begin
                        data_rd_d = mem[idx_q];
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            S_RESP: begin
                // Request lines still high here belong to the finished access; do not resample.
                state_d  = S_IDLE;
                cnt_d    = '0;
                mem_we_c = op_wr_q && !err_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_wr_q      <= 1'b0;
            idx_q        <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            data_valid_q <= 1'b0;
            data_error_q <= 1'b0;
            busy_q       <= 1'b0;
            data_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_wr_q      <= op_wr_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            data_valid_q <= data_valid_d;
            data_error_q <= data_error_d;
            busy_q       <= busy_d;
            data_rd_q    <= data_rd_d;
        end
    end

    // Byte-masked write commit at the end of the response cycle; a reset before then drops it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_Rd    = data_rd_q;
    assign bus.data_valid = data_valid_q;
    assign bus.data_error = data_error_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ysyx_040066_dmem_resp.sv
// Randomized self-checking bench for the data-memory responder at latencies 2, 1 and 15.
module tb_ysyx_040066_dmem_resp;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int          LAT2  = 2;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    // Reference memory for the latency-2 instance.
    logic [63:0] model [DEPTH];

    ysyx_040066_dmem_resp_if if2 ();
    ysyx_040066_dmem_resp_if if1 ();
    ysyx_040066_dmem_resp_if if15 ();

    ysyx_040066_dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );
    ysyx_040066_dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    ysyx_040066_dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(15)) dut15 (
        .clk(clk), .rst(rst), .bus(if15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Access faults as the data port defines them.
    function automatic bit exp_err(bit rd, bit wr, logic [63:0] a, logic [2:0] len);
        if (rd && wr) return 1'b1;
        if (len > 3'd3) return 1'b1;
        if ((a % (64'd1 << len)) != 64'd0) return 1'b1;
        if (a < BASE || a >= BASE + 64'(DEPTH) * 64'd8) return 1'b1;
        return 1'b0;
    endfunction

    // One access on the latency-2 instance; checks timing, busy, error and data against the model.
    task automatic do_access(input bit rd, input bit wr, input logic [63:0] a, input logic [2:0] len,
                             input logic [7:0] mask, input logic [63:0] wd, input bit drop,
                             input string tag, output logic [63:0] obs);
        bit          e;
        logic [63:0] exp_d;
        int unsigned wi;
        e     = exp_err(rd, wr, a, len);
        exp_d = 64'd0;
        wi    = 0;
        if (!e) wi = 32'((a - BASE) >> 3);
        if (!e && rd) exp_d = model[wi];
        if2.MemRd   = rd;
        if2.MemWr   = wr;
        if2.addr    = a;
        if2.wr_len  = len;
        if2.wr_mask = mask;
        if2.data_Wr = wd;
        for (int n = 1; n <= LAT2; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                // Scramble the bus after acceptance; the latched copy must be used.
                if2.addr    = {$urandom, $urandom};
                if2.data_Wr = {$urandom, $urandom};
                if2.wr_mask = 8'($urandom);
                if2.wr_len  = 3'($urandom);
                if (drop) begin
                    if2.MemRd = 1'b0;
                    if2.MemWr = 1'b0;
                end
            end
            vectors++;
            if (if2.data_valid !== 1'(n == LAT2)) begin
                miscompares++;
                $display("FAIL %s valid@%0d: got %b want %b", tag, n, if2.data_valid, n == LAT2);
            end
            vectors++;
            if (if2.busy !== 1'(n < LAT2)) begin
                miscompares++;
                $display("FAIL %s busy@%0d: got %b want %b", tag, n, if2.busy, n < LAT2);
            end
        end
        obs = if2.data_Rd;
        vectors++;
        if (if2.data_error !== e) begin
            miscompares++;
            $display("FAIL %s error: got %b want %b", tag, if2.data_error, e);
        end
        vectors++;
        if (if2.data_Rd !== exp_d) begin
            miscompares++;
            $display("FAIL %s data: got %h want %h", tag, if2.data_Rd, exp_d);
        end
        if2.MemRd = 1'b0;
        if2.MemWr = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (if2.data_valid !== 1'b0 || if2.data_Rd !== 64'd0) begin
            miscompares++;
            $display("FAIL %s after-resp: got valid=%b data=%h want 0/0", tag, if2.data_valid, if2.data_Rd);
        end
        if (wr && !e) begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) model[wi][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (if2.data_valid !== 1'b0 || if2.data_error !== 1'b0 || if2.busy !== 1'b0 || if2.data_Rd !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_l2: got v=%b e=%b b=%b d=%h want all 0",
                     if2.data_valid, if2.data_error, if2.busy, if2.data_Rd);
        end
        vectors++;
        if (if1.data_valid !== 1'b0 || if1.busy !== 1'b0 || if15.data_valid !== 1'b0 || if15.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_l1_l15: got v1=%b b1=%b v15=%b b15=%b want 0",
                     if1.data_valid, if1.busy, if15.data_valid, if15.busy);
        end
    endtask

    task automatic test_basic_read();
        logic [63:0] obs;
        do_access(1'b0, 1'b1, BASE, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, "preload", obs);
        do_access(1'b1, 1'b0, BASE, 3'd3, 8'h00, 64'd0, 1'b0, "read0", obs);
        vectors++;
        if (obs !== 64'h1122_3344_5566_7788) begin
            miscompares++;
            $display("FAIL read0_const: got %h want 1122334455667788", obs);
        end
    endtask

    task automatic test_partial_write();
        logic [63:0] obs;
        do_access(1'b0, 1'b1, BASE + 64'd8, 3'd3, 8'hFF, 64'd0, 1'b0, "clear1", obs);
        do_access(1'b0, 1'b1, BASE + 64'd8, 3'd3, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, "mask_wr", obs);
        do_access(1'b1, 1'b0, BASE + 64'd8, 3'd3, 8'h00, 64'd0, 1'b0, "mask_rd", obs);
        vectors++;
        if (obs !== 64'h0000_0000_CCCC_DDDD) begin
            miscompares++;
            $display("FAIL mask_rd_const: got %h want 00000000ccccdddd", obs);
        end
        do_access(1'b0, 1'b1, BASE + 64'd8, 3'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "mask0_wr", obs);
        do_access(1'b1, 1'b0, BASE + 64'd8, 3'd3, 8'h00, 64'd0, 1'b0, "mask0_rd", obs);
    endtask

    task automatic test_errors();
        logic [63:0] obs;
        do_access(1'b0, 1'b1, BASE + 64'd16, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, "pre2", obs);
        do_access(1'b1, 1'b0, BASE + 64'd2, 3'd2, 8'h00, 64'd0, 1'b0, "err_misalign", obs);
        do_access(1'b1, 1'b0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, 1'b0, "err_below", obs);
        do_access(1'b1, 1'b0, BASE + 64'(DEPTH) * 64'd8, 3'd3, 8'h00, 64'd0, 1'b0, "err_above", obs);
        do_access(1'b1, 1'b0, BASE, 3'd5, 8'h00, 64'd0, 1'b0, "err_len", obs);
        do_access(1'b1, 1'b1, BASE + 64'd16, 3'd3, 8'hFF, 64'hFFFF_0000_FFFF_0000, 1'b0, "err_rdwr", obs);
        do_access(1'b0, 1'b1, BASE + 64'd20, 3'd3, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, "err_wr_mis", obs);
        do_access(1'b1, 1'b0, BASE + 64'd16, 3'd3, 8'h00, 64'd0, 1'b0, "err_nowrite", obs);
        vectors++;
        if (obs !== 64'h0123_4567_89AB_CDEF) begin
            miscompares++;
            $display("FAIL err_nowrite_const: got %h want 0123456789abcdef", obs);
        end
    endtask

    task automatic test_back_to_back();
        int          first;
        int          second;
        int          count;
        logic [63:0] exp_d;
        exp_d = model[0];
        first = 0; second = 0; count = 0;
        if2.MemRd  = 1'b1;
        if2.MemWr  = 1'b0;
        if2.addr   = BASE;
        if2.wr_len = 3'd3;
        for (int n = 1; n <= 2 * LAT2 + 1; n++) begin
            @(posedge clk); #1;
            if (if2.data_valid === 1'b1) begin
                count++;
                if (count == 1) first = n;
                if (count == 2) second = n;
                vectors++;
                if (if2.data_Rd !== exp_d) begin
                    miscompares++;
                    $display("FAIL b2b data@%0d: got %h want %h", n, if2.data_Rd, exp_d);
                end
            end
        end
        if2.MemRd = 1'b0;
        vectors++;
        if (count != 2 || first != LAT2 || second - first != LAT2 + 1) begin
            miscompares++;
            $display("FAIL b2b timing: got count=%0d first=%0d second=%0d want 2/%0d/%0d",
                     count, first, second, LAT2, 2 * LAT2 + 1);
        end
        @(posedge clk); #1;
        vectors++;
        if (if2.data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b tail: got valid=%b want 0", if2.data_valid);
        end
    endtask

    task automatic test_flush();
        logic [63:0] obs;
        do_access(1'b0, 1'b1, BASE + 64'd24, 3'd3, 8'hF0, 64'h5555_6666_7777_8888, 1'b1, "flush_wr", obs);
        do_access(1'b1, 1'b0, BASE + 64'd24, 3'd3, 8'h00, 64'd0, 1'b1, "flush_rd", obs);
    endtask

    task automatic test_random();
        logic [63:0] obs;
        logic [63:0] a;
        logic [2:0]  len;
        bit          rd, wr;
        int          w, sel;
        for (int i = 0; i < 16; i++) begin
            do_access(1'b0, 1'b1, BASE + 64'(i) * 64'd8, 3'd3, 8'hFF, {$urandom, $urandom}, 1'b0, "rinit", obs);
        end
        for (int k = 0; k < 60; k++) begin
            w   = $urandom_range(0, 15);
            len = 3'($urandom_range(0, 3));
            a   = BASE + 64'(w) * 64'd8 + ((64'($urandom_range(0, 7)) >> len) << len);
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd;
            sel = $urandom_range(0, 19);
            case (sel)
                0: a = BASE - 64'd8 * 64'($urandom_range(1, 4));
                1: a = BASE + 64'(DEPTH) * 64'd8 + 64'd8 * 64'($urandom_range(0, 3));
                2: len = 3'($urandom_range(4, 7));
                3: begin len = 3'($urandom_range(1, 3)); a = BASE + 64'(w) * 64'd8 + 64'd1; end
                4: begin rd = 1'b1; wr = 1'b1; end
                default: ;
            endcase
            do_access(rd, wr, a, len, 8'($urandom), {$urandom, $urandom},
                      $urandom_range(0, 3) == 0, "rand", obs);
        end
        for (int i = 0; i < 16; i++) begin
            do_access(1'b1, 1'b0, BASE + 64'(i) * 64'd8, 3'd3, 8'h00, 64'd0, 1'b0, "rfinal", obs);
        end
    endtask

    task automatic test_latency_1();
        int          busy_cnt;
        logic [63:0] v;
        v = 64'hCAFE_F00D_1234_5678;
        for (int ph = 0; ph < 2; ph++) begin
            if1.MemRd   = (ph == 1);
            if1.MemWr   = (ph == 0);
            if1.addr    = BASE + 64'd40;
            if1.wr_len  = 3'd3;
            if1.wr_mask = 8'hFF;
            if1.data_Wr = v;
            busy_cnt    = 0;
            @(posedge clk); #1;
            if (if1.busy === 1'b1) busy_cnt++;
            vectors++;
            if (if1.data_valid !== 1'b1 || if1.data_error !== 1'b0) begin
                miscompares++;
                $display("FAIL lat1 ph%0d valid: got v=%b e=%b want 1/0", ph, if1.data_valid, if1.data_error);
            end
            vectors++;
            if (if1.data_Rd !== ((ph == 1) ? v : 64'd0) || busy_cnt != 0) begin
                miscompares++;
                $display("FAIL lat1 ph%0d data/busy: got %h busy=%0d want %h busy=0",
                         ph, if1.data_Rd, busy_cnt, (ph == 1) ? v : 64'd0);
            end
            if1.MemRd = 1'b0;
            if1.MemWr = 1'b0;
            @(posedge clk); #1;
            vectors++;
            if (if1.data_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL lat1 ph%0d tail: got valid=%b want 0", ph, if1.data_valid);
            end
        end
    endtask

    task automatic test_latency_15();
        int          busy_cnt;
        logic [63:0] v;
        v = 64'hDEAD_BEEF_0BAD_F00D;
        for (int ph = 0; ph < 2; ph++) begin
            if15.MemRd   = (ph == 1);
            if15.MemWr   = (ph == 0);
            if15.addr    = BASE + 64'd40;
            if15.wr_len  = 3'd3;
            if15.wr_mask = 8'hFF;
            if15.data_Wr = v;
            busy_cnt     = 0;
            for (int n = 1; n <= 15; n++) begin
                @(posedge clk); #1;
                if (if15.busy === 1'b1) busy_cnt++;
                vectors++;
                if (if15.data_valid !== 1'(n == 15)) begin
                    miscompares++;
                    $display("FAIL lat15 ph%0d valid@%0d: got %b want %b", ph, n, if15.data_valid, n == 15);
                end
            end
            vectors++;
            if (if15.data_Rd !== ((ph == 1) ? v : 64'd0) || busy_cnt != 14 || if15.data_error !== 1'b0) begin
                miscompares++;
                $display("FAIL lat15 ph%0d resp: got %h busy=%0d err=%b want %h busy=14 err=0",
                         ph, if15.data_Rd, busy_cnt, if15.data_error, (ph == 1) ? v : 64'd0);
            end
            if15.MemRd = 1'b0;
            if15.MemWr = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] obs;
        do_access(1'b0, 1'b1, BASE + 64'd56, 3'd3, 8'hFF, 64'h1357_9BDF_2468_ACE0, 1'b0, "rmw_pre", obs);
        if2.MemWr   = 1'b1;
        if2.addr    = BASE + 64'd56;
        if2.wr_len  = 3'd3;
        if2.wr_mask = 8'hFF;
        if2.data_Wr = 64'hFFFF_EEEE_DDDD_CCCC;
        @(posedge clk); #1;
        vectors++;
        if (if2.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rmw busy_before: got %b want 1", if2.busy);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (if2.busy !== 1'b0 || if2.data_valid !== 1'b0 || if2.data_Rd !== 64'd0 || if2.data_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rmw in_reset: got b=%b v=%b d=%h e=%b want 0",
                     if2.busy, if2.data_valid, if2.data_Rd, if2.data_error);
        end
        if2.MemWr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            vectors++;
            if (if2.data_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rmw no_pulse@%0d: got %b want 0", n, if2.data_valid);
            end
        end
        do_access(1'b1, 1'b0, BASE + 64'd56, 3'd3, 8'h00, 64'd0, 1'b0, "rmw_read", obs);
        vectors++;
        if (obs !== 64'h1357_9BDF_2468_ACE0) begin
            miscompares++;
            $display("FAIL rmw unchanged: got %h want 13579bdf2468ace0", obs);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        if2.MemRd  = 1'b0; if2.MemWr  = 1'b0; if2.addr  = 64'd0; if2.wr_len  = 3'd0; if2.wr_mask  = 8'd0; if2.data_Wr  = 64'd0;
        if1.MemRd  = 1'b0; if1.MemWr  = 1'b0; if1.addr  = 64'd0; if1.wr_len  = 3'd0; if1.wr_mask  = 8'd0; if1.data_Wr  = 64'd0;
        if15.MemRd = 1'b0; if15.MemWr = 1'b0; if15.addr = 64'd0; if15.wr_len = 3'd0; if15.wr_mask = 8'd0; if15.data_Wr = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic_read();
        test_partial_write();
        test_errors();
        test_back_to_back();
        test_flush();
        test_random();
        test_latency_1();
        test_latency_15();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
